debug_commit_tracer: RTL

//  Core-side producer of the per-instruction commit trace that feeds the SoC Debug/difftest sink.

---
 rtl/dbg_trace_pkg.sv | 27 ++
 rtl/dbg_dev_classifier.sv | 21 ++
 rtl/debug_commit_tracer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/dbg_trace_pkg.sv
// Shared types for the commit tracer.
//   state_e  : tracer FSM states
//   stage_t  : the one-deep stage record holding the last retired instruction
//   DEF_DEV_BASE / DEF_DEV_MASK : default MMIO device window
package dbg_trace_pkg;

  localparam logic [31:0] DEF_DEV_BASE = 32'ha000_0000;
  localparam logic [31:0] DEF_DEV_MASK = 32'hf000_0000;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    HELD   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_e;

  // pc is the retiring instruction's own pc. In DRAIN it holds the ebreak pc.
  // nxt is only meaningful when nxt_known is set.
  typedef struct packed {
    logic [31:0] pc;
    logic        dev;
    logic [31:0] addr;
    logic [31:0] nxt;
    logic        nxt_known;
  } stage_t;

endpackage

// File: rtl/dbg_dev_classifier.sv
// Combinational MMIO window match.
//   mem_en   in  : instruction accessed memory
//   addr     in  : effective address
//   dev      out : access falls in the device window
//   dev_addr out : addr when dev, else 0
module dbg_dev_classifier
  import dbg_trace_pkg::*;
#(
  parameter logic [31:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [31:0] DEV_MASK = DEF_DEV_MASK
) (
  input  logic        mem_en,
  input  logic [31:0] addr,
  output logic        dev,
  output logic [31:0] dev_addr
);

  assign dev      = mem_en && ((addr & DEV_MASK) == DEV_BASE);
  assign dev_addr = dev ? addr : 32'h0;

endmodule

// File: rtl/debug_commit_tracer.sv
// Per-instruction commit trace producer for the debug/difftest sink.
// A retired instruction is held one deep until its architectural next pc is
// known (next commit, same-cycle trap, or async interrupt), then reported.
// ebreak drains the held record and then emits a terminating halt record.
//   clock, reset (async, active-low)
//   commit_* : retire event from WB      trap_* : trap redirect event
//   debug_debugInfo_* : registered trace record, valid is a 1-cycle strobe
//   debug_intr : 1-cycle pulse per taken interrupt
//   commit_count : records emitted      halted : tracer stopped until reset
module debug_commit_tracer
  import dbg_trace_pkg::*;
#(
  parameter logic [31:0] DEV_BASE = DEF_DEV_BASE,
  parameter logic [31:0] DEV_MASK = DEF_DEV_MASK,
  parameter int          CNT_W    = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             commit_valid,
  input  logic [31:0]      commit_pc,
  input  logic             commit_ebreak,
  input  logic             commit_mem_en,
  input  logic [31:0]      commit_mem_addr,
  input  logic             trap_valid,
  input  logic [31:0]      trap_pc,
  input  logic [31:0]      trap_cause,
  output logic             debug_debugInfo_valid,
  output logic             debug_debugInfo_halt,
  output logic             debug_debugInfo_deviceAccess,
  output logic [31:0]      debug_debugInfo_deviceAddr,
  output logic [31:0]      debug_debugInfo_pc,
  output logic             debug_intr,
  output logic [CNT_W-1:0] commit_count,
  output logic             halted
);

  logic        cls_dev;
  logic [31:0] cls_addr;

  dbg_dev_classifier #(
    .DEV_BASE (DEV_BASE),
    .DEV_MASK (DEV_MASK)
  ) u_cls (
    .mem_en   (commit_mem_en),
    .addr     (commit_mem_addr),
    .dev      (cls_dev),
    .dev_addr (cls_addr)
  );

  state_e      state, nxt_st;
  stage_t      stg, new_stg;
  logic        emit, emit_halt, load, latch_halt;
  logic [31:0] emit_pc;

  assign new_stg = '{pc: commit_pc, dev: cls_dev, addr: cls_addr,
                     nxt: trap_pc, nxt_known: trap_valid};

  // Decide what (if anything) is reported on the next edge and where S goes.
  always_comb begin
    emit       = 1'b0;
    emit_halt  = 1'b0;
    emit_pc    = stg.nxt;
    load       = 1'b0;
    latch_halt = 1'b0;
    nxt_st     = state;
    case (state)
      EMPTY: if (commit_valid) begin
        if (commit_ebreak) begin
          // nothing pending: halt record goes out directly, no DRAIN
          emit      = 1'b1;
          emit_halt = 1'b1;
          emit_pc   = commit_pc;
          nxt_st    = HALTED;
        end else begin
          load   = 1'b1;
          nxt_st = HELD;
        end
      end
      HELD: begin
        if (stg.nxt_known) begin
          emit    = 1'b1;
          emit_pc = stg.nxt;
        end else if (commit_valid) begin
          emit    = 1'b1;
          emit_pc = commit_pc;
        end else if (trap_valid) begin
          emit    = 1'b1;
          emit_pc = trap_pc;
        end
        // once S is flushed the slot is free for this cycle's commit
        if (emit) begin
          if (!commit_valid) begin
            nxt_st = EMPTY;
          end else if (commit_ebreak) begin
            latch_halt = 1'b1;
            nxt_st     = DRAIN;
          end else begin
            load = 1'b1;
          end
        end
      end
      DRAIN: begin
        emit      = 1'b1;
        emit_halt = 1'b1;
        emit_pc   = stg.pc;
        nxt_st    = HALTED;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                        <= EMPTY;
      stg                          <= '0;
      debug_debugInfo_valid        <= 1'b0;
      debug_debugInfo_halt         <= 1'b0;
      debug_debugInfo_deviceAccess <= 1'b0;
      debug_debugInfo_deviceAddr   <= '0;
      debug_debugInfo_pc           <= '0;
      debug_intr                   <= 1'b0;
      commit_count                 <= '0;
      halted                       <= 1'b0;
    end else begin
      state                        <= nxt_st;
      halted                       <= (nxt_st == HALTED);
      debug_intr                   <= trap_valid && trap_cause[31] && (state != HALTED);
      debug_debugInfo_valid        <= emit;
      debug_debugInfo_halt         <= emit && emit_halt;
      debug_debugInfo_deviceAccess <= emit && !emit_halt && stg.dev;
      debug_debugInfo_deviceAddr   <= (emit && !emit_halt) ? stg.addr : 32'h0;
      debug_debugInfo_pc           <= emit ? emit_pc : 32'h0;
      if (emit) commit_count <= commit_count + CNT_W'(1);
      if (load)            stg <= new_stg;
      else if (latch_halt) stg <= '{pc: commit_pc, default: '0};
    end
  end

endmodule
